inst_rom_rsp: RTL and testbench

- Instruction-memory responder on the fetch interface: the target of the pc/ce fetch request.
- Holds program words in an internal RAM and returns one instruction per enabled cycle, one cycle after the request.
- After reset it clears itself with a state machine; while that runs it answers fetches with NOP and refuses loads.
- A side load port lets the testbench or boot logic write program words once memory is ready.

---
 rtl/inst_rom_rsp.sv | 107 ++++++++++
 tb/tb_inst_rom_rsp.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/inst_rom_rsp.sv
// Instruction-memory responder: clears its RAM after reset, then serves one
// registered fetch per enabled cycle and accepts program writes on a side port.
module inst_rom_rsp #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] NOP_WORD   = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] addr,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        addr_err,
  output logic        init_done,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ready
);

  // state | meaning
  // INIT  | writing zero to every RAM word, one per cycle; fetches get NOP, loads dropped
  // RUN   | normal service; terminal until the next reset

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] clr_cnt, clr_cnt_nxt;
  logic [31:0]           mem [DEPTH];

  logic                  fetch_legal, ld_legal;
  logic [DEPTH_LOG2-1:0] fetch_idx, ld_idx;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [31:0]           wr_data;

  assign fetch_idx   = addr[DEPTH_LOG2+1:2];
  assign ld_idx      = ld_addr[DEPTH_LOG2+1:2];
  assign fetch_legal = (addr[1:0] == 2'b00) && !(|addr[31:DEPTH_LOG2+2]);
  assign ld_legal    = (ld_addr[1:0] == 2'b00) && !(|ld_addr[31:DEPTH_LOG2+2]);

  assign init_done = (state == RUN);
  assign ld_ready  = init_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // The single RAM write port is shared by the clear sequence and the load port.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    wr_en       = 1'b0;
    wr_idx      = ld_idx;
    wr_data     = ld_data;
    case (state)
      INIT: begin
        wr_en       = 1'b1;
        wr_idx      = clr_cnt;
        wr_data     = '0;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (&clr_cnt) state_nxt = RUN;
      end
      RUN: begin
        wr_en = ld_en && ld_legal;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Read sees the pre-write word on a same-cycle load to the same index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst       <= NOP_WORD;
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      inst       <= NOP_WORD;
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;
      if (ce && state == RUN) begin
        if (fetch_legal) begin
          inst       <= mem[fetch_idx];
          inst_valid <= 1'b1;
        end else begin
          addr_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_rom_rsp.sv
// Scoreboard bench for inst_rom_rsp with DEPTH_LOG2=4: directed fetch/load
// scenarios followed by random traffic, checked against a word-array model.
module tb_inst_rom_rsp;

  localparam int DL2 = 4;
  localparam int WORDS = 1 << DL2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] inst;
  logic        inst_valid, addr_err, init_done;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        ld_ready;

  inst_rom_rsp #(.DEPTH_LOG2(DL2), .NOP_WORD(32'h00000000)) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
    .inst_valid(inst_valid), .addr_err(addr_err), .init_done(init_done),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        v;
    logic        e;
    logic        d;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mdl [WORDS];
  int          edges = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 4 * WORDS);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < WORDS; i++) mdl[i] = 32'h0;
    edges = 0;
  endtask

  // Called at a falling edge; covers exactly one rising edge.
  task automatic step(input logic c, input logic [31:0] a, input logic le,
                      input logic [31:0] la, input logic [31:0] ldat);
    exp_t x;
    bit   rdy;
    ce = c; addr = a; ld_en = le; ld_addr = la; ld_data = ldat;
    rdy    = (edges >= WORDS);
    x.inst = 32'h0;
    x.v    = 1'b0;
    x.e    = 1'b0;
    x.d    = (edges + 1 >= WORDS);
    if (c && rdy) begin
      if (legal(a)) begin
        x.inst = mdl[int'(a >> 2)];
        x.v    = 1'b1;
      end else begin
        x.e = 1'b1;
      end
    end
    q.push_back(x);
    if (le && rdy && legal(la)) mdl[int'(la >> 2)] = ldat;
    edges++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_valid"}, {31'h0, inst_valid}, 32'h0);
    chk({tag, "_err"}, {31'h0, addr_err}, 32'h0);
    chk({tag, "_init_done"}, {31'h0, init_done}, 32'h0);
    chk({tag, "_ld_ready"}, {31'h0, ld_ready}, 32'h0);
  endtask

  // Monitor: the DUT presents a registered response after every rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if (inst !== x.inst || inst_valid !== x.v || addr_err !== x.e ||
            init_done !== x.d || ld_ready !== x.d) begin
          errors++;
          $display("FAIL rsp t=%0t actual inst=%h v=%b e=%b done=%b rdy=%b required inst=%h v=%b e=%b done=%b",
                   $time, inst, inst_valid, addr_err, init_done, ld_ready, x.inst, x.v, x.e, x.d);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, la;
    int r;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");

    rst = 1'b0;
    // INIT: fetches answer NOP, loads of DEADBEEF are dropped
    for (int i = 0; i < WORDS; i++) step(1'b1, 32'h0, 1'b1, 32'h0, 32'hDEADBEEF);

    step(1'b0, 32'h0, 1'b1, 32'h0, 32'h34011100);
    step(1'b0, 32'h0, 1'b1, 32'h4, 32'h34020020);
    step(1'b0, 32'h0, 1'b1, 32'h8, 32'h3403FF00);
    step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h8, 1'b0, 32'h0, 32'h0);

    step(1'b1, 32'h2, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h40, 1'b0, 32'h0, 32'h0);

    step(1'b1, 32'h4, 1'b1, 32'h4, 32'h11111111);
    step(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);

    step(1'b0, 32'h8, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h3, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'hC, 1'b0, 32'h0, 32'h0);

    // Asynchronous reset between edges while in RUN
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async_rst");
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("held_rst");
    rst = 1'b0;
    model_reset();
    idle(WORDS);
    step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, WORDS - 1)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, WORDS - 1)) << 2) + 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'(4 * WORDS) + (32'($urandom_range(0, 255)) << 2);
      else             a = $urandom;
      r = $urandom_range(0, 9);
      if (r < 8) la = 32'($urandom_range(0, WORDS - 1)) << 2;
      else       la = $urandom;
      step($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) == 0, la, $urandom);
    end

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
